// File: rtl/exc_ctrl_unit.sv
// Exception controller: latches and prioritises IRQs, takes undefined-opcode traps,
// captures ELR/ESR, redirects the PC to the vector and services ERET.

// One interrupt line: rising-edge detector plus its pending latch.
module exc_irq_line (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  input  logic en,
  input  logic take,
  output logic pending
);
  logic irq_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q   <= 1'b0;
      pending <= 1'b0;
    end else begin
      irq_q <= irq;
      // A fresh edge wins over a simultaneous take so the new request is not lost.
      if (irq & en & ~irq_q) pending <= 1'b1;
      else if (take)         pending <= 1'b0;
    end
  end
endmodule

module exc_ctrl_unit #(
  parameter int                N_IRQ    = 4,
  parameter int                PC_W     = 64,
  parameter int                EST_W    = 4,
  parameter logic [PC_W-1:0]   VEC_ADDR = 'hD8,
  parameter logic [EST_W-1:0]  UND_CODE = 4'b0010
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             not_instr_i,
  input  logic             eret_i,
  input  logic [PC_W-1:0]  pc_i,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic [N_IRQ-1:0] irq_en_i,
  output logic             exc_o,
  output logic [PC_W-1:0]  vec_o,
  output logic             eret_o,
  output logic [PC_W-1:0]  elr_o,
  output logic [EST_W-1:0] esr_o,
  output logic             in_handler_o,
  output logic [N_IRQ-1:0] pending_o,
  output logic             fault_o
);
  typedef enum logic {RUN, HANDLER} state_t;

  state_t             state, state_nxt;
  logic [N_IRQ-1:0]   req, sel, take;
  logic [EST_W-2:0]   idx;
  logic               found;
  logic               exc_nxt, eret_nxt, fault_set, capture;
  logic [EST_W-1:0]   esr_nxt;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_line
    exc_irq_line u_line (
      .clk     (clk),
      .reset   (reset),
      .irq     (irq_i[g]),
      .en      (irq_en_i[g]),
      .take    (take[g]),
      .pending (pending_o[g])
    );
  end

  // Masked lines stay pending but are invisible to arbitration.
  assign req = pending_o & irq_en_i;

  // Descending scan so the lowest requesting index is the one left standing.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sel   = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        found  = 1'b1;
        idx    = (EST_W-1)'(i);
        sel    = '0;
        sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    exc_nxt   = 1'b0;
    eret_nxt  = 1'b0;
    fault_set = 1'b0;
    capture   = 1'b0;
    esr_nxt   = esr_o;
    take      = '0;
    case (state)
      RUN: begin
        if (not_instr_i) begin
          exc_nxt   = 1'b1;
          capture   = 1'b1;
          esr_nxt   = UND_CODE;
          state_nxt = HANDLER;
        end else if (found) begin
          exc_nxt   = 1'b1;
          capture   = 1'b1;
          esr_nxt   = {1'b1, idx};
          take      = sel;
          state_nxt = HANDLER;
        end
      end
      HANDLER: begin
        if (not_instr_i) begin
          fault_set = 1'b1;
        end else if (eret_i) begin
          eret_nxt  = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      exc_o   <= 1'b0;
      eret_o  <= 1'b0;
      elr_o   <= '0;
      esr_o   <= '0;
      fault_o <= 1'b0;
    end else begin
      state  <= state_nxt;
      exc_o  <= exc_nxt;
      eret_o <= eret_nxt;
      if (capture) begin
        elr_o <= pc_i;
        esr_o <= esr_nxt;
      end
      if (fault_set) fault_o <= 1'b1;
    end
  end

  assign in_handler_o = (state == HANDLER);
  assign vec_o        = VEC_ADDR;
endmodule

// File: tb/tb_exc_ctrl_unit.sv
// Directed bench for exc_ctrl_unit: a vector table of one-cycle steps plus
// hand-written sequences for ERET/undefined collisions and line masking.
module tb_exc_ctrl_unit;
  logic        clk = 1'b0;
  logic        reset, not_instr_i, eret_i;
  logic [63:0] pc_i;
  logic [3:0]  irq_i, irq_en_i;
  logic        exc_o, eret_o, in_handler_o, fault_o;
  logic [63:0] vec_o, elr_o;
  logic [3:0]  esr_o, pending_o;

  int checks = 0;
  int errors = 0;

  exc_ctrl_unit dut (
    .clk          (clk),
    .reset        (reset),
    .not_instr_i  (not_instr_i),
    .eret_i       (eret_i),
    .pc_i         (pc_i),
    .irq_i        (irq_i),
    .irq_en_i     (irq_en_i),
    .exc_o        (exc_o),
    .vec_o        (vec_o),
    .eret_o       (eret_o),
    .elr_o        (elr_o),
    .esr_o        (esr_o),
    .in_handler_o (in_handler_o),
    .pending_o    (pending_o),
    .fault_o      (fault_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ni, er;
    logic [63:0] pc;
    logic [3:0]  irq, en;
    logic        exc, ereto;
    logic [63:0] elr;
    logic [3:0]  esr;
    logic        inh;
    logic [3:0]  pend;
    logic        fault;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rst, logic ni, logic er, logic [63:0] pc,
                              logic [3:0] irq, logic [3:0] en, logic exc, logic ereto,
                              logic [63:0] elr, logic [3:0] esr, logic inh,
                              logic [3:0] pend, logic fault);
    vec_t v;
    v.rst = rst; v.ni = ni; v.er = er; v.pc = pc; v.irq = irq; v.en = en;
    v.exc = exc; v.ereto = ereto; v.elr = elr; v.esr = esr; v.inh = inh;
    v.pend = pend; v.fault = fault;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then compare every output just after the edge.
  task automatic apply(input string tag, input vec_t v);
    reset = v.rst; not_instr_i = v.ni; eret_i = v.er;
    pc_i = v.pc; irq_i = v.irq; irq_en_i = v.en;
    @(posedge clk); #1;
    chk({tag, ".exc"},   64'(exc_o),        64'(v.exc));
    chk({tag, ".eret"},  64'(eret_o),       64'(v.ereto));
    chk({tag, ".elr"},   elr_o,             v.elr);
    chk({tag, ".esr"},   64'(esr_o),        64'(v.esr));
    chk({tag, ".inh"},   64'(in_handler_o), 64'(v.inh));
    chk({tag, ".pend"},  64'(pending_o),    64'(v.pend));
    chk({tag, ".fault"}, 64'(fault_o),      64'(v.fault));
    chk({tag, ".both"},  64'(exc_o & eret_o), 64'(0));
  endtask

  initial begin
    reset = 1'b1; not_instr_i = 1'b0; eret_i = 1'b0;
    pc_i = '0; irq_i = '0; irq_en_i = '0;

    //         rst ni er pc      irq     en      exc er elr     esr     inh pend   flt
    // reset
    vq.push_back(mk(1, 0, 0, 64'h0,  4'h0,   4'h0,  0, 0, 64'h0,  4'h0,   0, 4'h0,   0));
    vq.push_back(mk(1, 0, 0, 64'h0,  4'h0,   4'h0,  0, 0, 64'h0,  4'h0,   0, 4'h0,   0));
    vq.push_back(mk(1, 0, 0, 64'h0,  4'h0,   4'h0,  0, 0, 64'h0,  4'h0,   0, 4'h0,   0));
    // undefined opcode, then ERET back
    vq.push_back(mk(0, 1, 0, 64'h40, 4'h0,   4'hF,  1, 0, 64'h40, 4'b0010, 1, 4'h0,  0));
    vq.push_back(mk(0, 0, 1, 64'h44, 4'h0,   4'hF,  0, 1, 64'h40, 4'b0010, 0, 4'h0,  0));
    vq.push_back(mk(0, 0, 0, 64'h48, 4'h0,   4'hF,  0, 0, 64'h40, 4'b0010, 0, 4'h0,  0));
    // two IRQs rise together: latched first, line1 then line3
    vq.push_back(mk(0, 0, 0, 64'h4C, 4'b1010, 4'hF, 0, 0, 64'h40, 4'b0010, 0, 4'b1010, 0));
    vq.push_back(mk(0, 0, 0, 64'h50, 4'b1010, 4'hF, 1, 0, 64'h50, 4'b1001, 1, 4'b1000, 0));
    vq.push_back(mk(0, 0, 1, 64'hD8, 4'b1010, 4'hF, 0, 1, 64'h50, 4'b1001, 0, 4'b1000, 0));
    vq.push_back(mk(0, 0, 0, 64'h54, 4'b1010, 4'hF, 1, 0, 64'h54, 4'b1011, 1, 4'b0000, 0));
    // double fault in handler, ERET still works, fault sticky
    vq.push_back(mk(0, 1, 0, 64'hD8, 4'h0,   4'hF,  0, 0, 64'h54, 4'b1011, 1, 4'h0,  1));
    vq.push_back(mk(0, 0, 1, 64'hDC, 4'h0,   4'hF,  0, 1, 64'h54, 4'b1011, 0, 4'h0,  1));
    vq.push_back(mk(0, 0, 0, 64'h60, 4'h0,   4'hF,  0, 0, 64'h54, 4'b1011, 0, 4'h0,  1));
    // edge on a disabled line is lost for good
    vq.push_back(mk(0, 0, 0, 64'h64, 4'b0100, 4'b1011, 0, 0, 64'h54, 4'b1011, 0, 4'h0, 1));
    vq.push_back(mk(0, 0, 0, 64'h68, 4'b0100, 4'hF,    0, 0, 64'h54, 4'b1011, 0, 4'h0, 1));
    vq.push_back(mk(0, 0, 0, 64'h6C, 4'b0100, 4'hF,    0, 0, 64'h54, 4'b1011, 0, 4'h0, 1));
    // reset mid-handler with a pending line
    vq.push_back(mk(0, 1, 0, 64'h70, 4'b0000, 4'hF, 1, 0, 64'h70, 4'b0010, 1, 4'h0,    1));
    vq.push_back(mk(0, 0, 0, 64'hD8, 4'b0100, 4'hF, 0, 0, 64'h70, 4'b0010, 1, 4'b0100, 1));
    vq.push_back(mk(1, 0, 0, 64'hDC, 4'b0100, 4'hF, 0, 0, 64'h0,  4'h0,    0, 4'h0,    0));

    chk("vec_const", vec_o, 64'hD8);
    foreach (vq[i]) apply($sformatf("row%0d", i), vq[i]);

    // ERET in RUN is ignored; ERET together with undefined opcode lets the trap win
    apply("s_rst",  mk(1, 0, 0, 64'h0,   4'h0, 4'h0, 0, 0, 64'h0,   4'h0,    0, 4'h0, 0));
    apply("s_eret", mk(0, 0, 1, 64'h100, 4'h0, 4'h0, 0, 0, 64'h0,   4'h0,    0, 4'h0, 0));
    apply("s_both", mk(0, 1, 1, 64'h104, 4'h0, 4'h0, 1, 0, 64'h104, 4'b0010, 1, 4'h0, 0));
    apply("s_hboth",mk(0, 1, 1, 64'hD8,  4'h0, 4'h0, 0, 0, 64'h104, 4'b0010, 1, 4'h0, 1));
    apply("s_ret",  mk(0, 0, 1, 64'hDC,  4'h0, 4'h0, 0, 1, 64'h104, 4'b0010, 0, 4'h0, 1));
    // masking holds a pending line without taking it; re-enable takes it
    apply("s_lat",  mk(0, 0, 0, 64'h1F0, 4'h1, 4'h1, 0, 0, 64'h104, 4'b0010, 0, 4'h1, 1));
    apply("s_msk1", mk(0, 0, 0, 64'h1F4, 4'h1, 4'h0, 0, 0, 64'h104, 4'b0010, 0, 4'h1, 1));
    apply("s_msk2", mk(0, 0, 0, 64'h1F8, 4'h1, 4'h0, 0, 0, 64'h104, 4'b0010, 0, 4'h1, 1));
    apply("s_take", mk(0, 0, 0, 64'h200, 4'h1, 4'h1, 1, 0, 64'h200, 4'b1000, 1, 4'h0, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
